// File: rtl/coarse_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// coarse_peak_finder_pkg
//
// Shared definitions for the coarse peak finder:
//   - default widths for the coarse bin index (Nb), the TDC code (Np),
//     the per-bin counter (Nc) and the number of valid codes per
//     acquisition (NEVT);
//   - the control FSM state encoding.
// -----------------------------------------------------------------------------
package coarse_peak_finder_pkg;

    // Coarse bin index width: 2**NB_DEFAULT histogram bins.
    localparam int NB_DEFAULT   = 4;
    // TDC timestamp width; the top Nb bits select the coarse bin.
    localparam int NP_DEFAULT   = 8;
    // Per-bin counter width; counts saturate at 2**Nc-1.
    localparam int NC_DEFAULT   = 8;
    // Valid codes accepted per acquisition before the scan starts.
    localparam int NEVT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } cpf_state_t;

endpackage : coarse_peak_finder_pkg

// File: rtl/coarse_peak_finder_histogram_ram.sv
// -----------------------------------------------------------------------------
// histogram_ram
//
// Bin storage for the coarse peak finder: 2**AW words of DW bits, one
// synchronous write port and one registered read port. A read of an address
// being written in the same cycle returns the old contents; the owner is
// responsible for forwarding. Contents are not reset.
//
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (sampled on the rising edge)
//   rdata  - registered read data, valid the cycle after raddr
// -----------------------------------------------------------------------------
module histogram_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule : histogram_ram

// File: rtl/coarse_peak_finder.sv
// -----------------------------------------------------------------------------
// coarse_peak_finder
//
// Builds a coarse histogram of TDC timestamps and reports the fullest bin.
// On start the histogram is cleared one bin per cycle (CLEAR), then NEVT
// valid codes are binned by their top Nb bits (ACCUM), then all bins are
// read in ascending order to find the maximum (SCAN), and the result is
// presented together with a one-cycle peakDone pulse (DONE).
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin an acquisition, only honoured in IDLE
//   tdcValid   - qualifies tdcCode, only honoured in ACCUM
//   tdcCode    - TDC timestamp, top Nb bits select the bin
//   peakCH     - index of the fullest bin (lowest index on ties)
//   peakCount  - count held in peakCH (saturating)
//   peakDone   - one-cycle pulse, peakCH/peakCount valid in that cycle
//   busy       - high in every state except IDLE
// -----------------------------------------------------------------------------
module coarse_peak_finder
    import coarse_peak_finder_pkg::*;
#(
    parameter int Nb   = NB_DEFAULT,
    parameter int Np   = NP_DEFAULT,
    parameter int Nc   = NC_DEFAULT,
    parameter int NEVT = NEVT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          tdcValid,
    input  logic [Np-1:0] tdcCode,
    output logic [Nb-1:0] peakCH,
    output logic [Nc-1:0] peakCount,
    output logic          peakDone,
    output logic          busy
);

    localparam int            EW       = $clog2(NEVT + 1);
    localparam logic [Nb-1:0] LAST_BIN = '1;
    localparam logic [Nc-1:0] CNT_MAX  = '1;
    localparam logic [EW-1:0] EVT_LAST = EW'(NEVT - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    cpf_state_t    state_reg, state_next;
    logic [Nb-1:0] addr_reg, addr_next;     // clear / scan bin index
    logic [EW-1:0] evt_reg, evt_next;       // accepted codes this run

    // Increment pipeline: stage 1 issues the read, stage 2 writes back.
    logic          s2_valid_reg;
    logic [Nb-1:0] s2_bin_reg;

    // Last write issued to the RAM, used to patch read-during-write data.
    logic          lw_valid_reg;
    logic [Nb-1:0] lw_addr_reg;
    logic [Nc-1:0] lw_data_reg;

    // Address whose data is currently on ram_rdata.
    logic [Nb-1:0] raddr_q_reg;

    // Max tracking.
    logic          cmp_valid_reg;           // ram_rdata holds a scanned bin
    logic [Nb-1:0] run_ch_reg;
    logic [Nc-1:0] run_cnt_reg;
    logic [Nb-1:0] peak_ch_reg;
    logic [Nc-1:0] peak_cnt_reg;

    // RAM port signals.
    logic          ram_we;
    logic [Nb-1:0] ram_waddr;
    logic [Nc-1:0] ram_wdata;
    logic [Nb-1:0] ram_raddr;
    logic [Nc-1:0] ram_rdata;

    logic [Nb-1:0] code_bin;
    logic          accept;
    logic [Nc-1:0] bin_data;
    logic [Nc-1:0] inc_data;
    logic [Nb-1:0] cand_ch;
    logic [Nc-1:0] cand_cnt;

    assign code_bin = tdcCode[Np-1 -: Nb];
    assign accept   = (state_reg == ST_ACCUM) && tdcValid;

    // The fine part of the timestamp plays no role in coarse binning.
    generate
        if (Np > Nb) begin : g_fine_bits
            logic fine_unused;
            assign fine_unused = ^tdcCode[Np-Nb-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bin storage
    // ------------------------------------------------------------------
    histogram_ram #(
        .AW (Nb),
        .DW (Nc)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The RAM returns old data when the same address was written on the
    // edge that captured the read; the write that happened on that edge is
    // the only one that can be missing, so a single-entry bypass suffices.
    // This covers back-to-back increments of one bin and the scan of a bin
    // whose final increment lands in the first SCAN cycle.
    assign bin_data = (lw_valid_reg && (lw_addr_reg == raddr_q_reg)) ? lw_data_reg
                                                                     : ram_rdata;
    assign inc_data = (bin_data == CNT_MAX) ? bin_data : bin_data + 1'b1;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s2_bin_reg;
        ram_wdata = inc_data;
        if (state_reg == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = addr_reg;
            ram_wdata = '0;
        end else if (s2_valid_reg) begin
            ram_we    = 1'b1;
        end
        ram_raddr = (state_reg == ST_ACCUM) ? code_bin : addr_reg;
    end

    // ------------------------------------------------------------------
    // Max tracking: strictly greater replaces, so ties keep the lower bin.
    // ------------------------------------------------------------------
    always_comb begin
        cand_ch  = run_ch_reg;
        cand_cnt = run_cnt_reg;
        if (cmp_valid_reg && (bin_data > run_cnt_reg)) begin
            cand_ch  = raddr_q_reg;
            cand_cnt = bin_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        evt_next   = evt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                    addr_next  = '0;
                end
            end
            ST_CLEAR: begin
                // addr wraps back to 0 on leaving, ready for the scan.
                addr_next = addr_reg + 1'b1;
                if (addr_reg == LAST_BIN) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (tdcValid) begin
                    if (evt_reg == EVT_LAST) begin
                        evt_next   = '0;
                        addr_next  = '0;
                        state_next = ST_SCAN;
                    end else begin
                        evt_next = evt_reg + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                addr_next = addr_reg + 1'b1;
                if (addr_reg == LAST_BIN) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            evt_reg       <= '0;
            s2_valid_reg  <= 1'b0;
            lw_valid_reg  <= 1'b0;
            cmp_valid_reg <= 1'b0;
            peak_ch_reg   <= '0;
            peak_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            evt_reg       <= evt_next;
            s2_valid_reg  <= accept;
            lw_valid_reg  <= ram_we;
            cmp_valid_reg <= (state_reg == ST_SCAN);
            if (state_reg == ST_DONE) begin
                peak_ch_reg  <= cand_ch;
                peak_cnt_reg <= cand_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset needed; qualified by control above)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        s2_bin_reg  <= code_bin;
        lw_addr_reg <= ram_waddr;
        lw_data_reg <= ram_wdata;
        raddr_q_reg <= ram_raddr;
        // The running maximum is cleared while accumulating so every scan
        // starts from (0, 0); an empty histogram therefore reports (0, 0).
        if (state_reg == ST_ACCUM) begin
            run_ch_reg  <= '0;
            run_cnt_reg <= '0;
        end else if (cmp_valid_reg) begin
            run_ch_reg  <= cand_ch;
            run_cnt_reg <= cand_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the last bin's comparison completes in DONE, so the result
    // is taken straight from the comparator in that cycle and held after.
    // ------------------------------------------------------------------
    assign peakDone  = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign peakCH    = (state_reg == ST_DONE) ? cand_ch  : peak_ch_reg;
    assign peakCount = (state_reg == ST_DONE) ? cand_cnt : peak_cnt_reg;

endmodule : coarse_peak_finder
